// File: rtl/shift_unit_pkg.sv
// Shared definitions for the multi-cycle shift unit: mode encoding and FSM states.
package shift_unit_pkg;

  // Shift mode encoding presented on in_mode
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : shift_unit_pkg

// File: rtl/shift_unit_shift_step.sv
// Combinational shift of a WIDTH-bit value by 0..STEP positions in one of four modes.
// Only constant-distance shifts are built, so the cost grows with STEP, not WIDTH.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 2,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [KW-1:0]    i_amt,
  input  logic [1:0]       i_mode,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data
);

  // Select among the STEP+1 constant-distance shifts for the requested mode
  always_comb begin
    // NOTE: default assignment first so every path drives o_data and no latch is inferred.
    o_data = i_data;
    for (int k = 0; k <= STEP; k++) begin
      if (i_amt == KW'(k)) begin
        unique case (i_mode)
          MODE_SLL: o_data = i_data << k;
          MODE_SRL: o_data = i_data >> k;
          MODE_SRA: o_data = ({WIDTH{i_fill}} << (WIDTH - k)) | (i_data >> k);
          MODE_ROL: o_data = (i_data << k) | (i_data >> (WIDTH - k));
          default:  o_data = i_data;
        endcase
      end
    end
  end

endmodule : shift_step

// File: rtl/shift_unit.sv
// Iterative shifter: accepts an operand, shifts it by up to STEP bits per cycle until the
// requested distance is covered, then holds the result until the consumer takes it.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  STEP  = 2,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int KW = $clog2(STEP + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [AW-1:0]    r_rem;
  logic [1:0]       r_mode;

  logic [AW:0]      w_rem_ext;
  logic [AW:0]      w_step_max;
  logic [AW:0]      w_k;
  logic [WIDTH-1:0] w_step_out;

  // Distance covered this cycle: k = min(STEP, remaining)
  always_comb begin
    w_rem_ext  = {1'b0, r_rem};
    w_step_max = (AW + 1)'(STEP);
    w_k        = (w_rem_ext > w_step_max) ? w_step_max : w_rem_ext;
  end

  // The arithmetic-shift fill comes from the working MSB, which keeps the captured sign
  // because at most WIDTH-1 positions are ever shifted.
  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_shift_step (
    .i_data (r_work),
    .i_amt  (KW'(w_k)),
    .i_mode (r_mode),
    .i_fill (r_work[WIDTH-1]),
    .o_data (w_step_out)
  );

  // Control FSM with capture, per-cycle shift and result hold
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is cleared by reset so an aborted operation leaves no residue.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_mode  <= MODE_SLL;
    end else begin
      // NOTE: non-blocking assignments so all state updates use pre-edge values.
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work  <= in_data;
            r_rem   <= in_amt;
            r_mode  <= in_mode;
            r_state <= (in_amt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_work <= w_step_out;
          r_rem  <= r_rem - w_k[AW-1:0];
          if (r_rem == w_k[AW-1:0]) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags decode the registered state; result flag follows the working register
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_work;
  assign out_zero  = (r_work == '0);

endmodule : shift_unit

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; power of two, minimum 4.
REQ-002 Parameter STEP, default 2: maximum bit positions shifted per clock cycle; range 1..WIDTH.
REQ-003 Local constant AW = log2(WIDTH): shift-amount width.
REQ-004 Port clk  input  1: single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port in_valid  input  1: operand, amount and mode are presented.
REQ-007 Port in_ready  output  1: unit accepts a new operation.
REQ-008 Port in_data  input  WIDTH: operand.
REQ-009 Port in_amt  input  AW: shift distance, 0..WIDTH-1.
REQ-010 Port in_mode  input  2: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-011 Port out_valid  output  1: result is available.
REQ-012 Port out_ready  input  1: consumer takes the result.
REQ-013 Port out_data  output  WIDTH: shifted result.
REQ-014 Port out_zero  output  1: out_data equals zero.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept = in_valid & in_ready at a rising edge; on accept, in_data, in_amt and in_mode SHALL be captured into internal registers; later input changes SHALL be ignored.
REQ-018 On accept with in_amt = 0 the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-019 In SHIFT, each cycle SHALL shift the working register by k = min(STEP, remaining) per the captured mode, and SHALL decrement remaining by k.
REQ-020 When remaining reaches 0 after an update, the next state SHALL be DONE.
REQ-021 Latency from accept edge to out_valid high SHALL be 1 cycle for amt = 0, otherwise 1 + ceil(amt/STEP) cycles.
REQ-022 Mode semantics:
- SLL: zero fill at the LSB.
- SRL: zero fill at the MSB.
- SRA: fill with the captured operand's MSB.
- ROL: bits leaving the MSB re-enter at the LSB.
REQ-023 The final result SHALL equal a single-step shift by the full amount (step decomposition invisible).
REQ-024 In DONE, out_data and out_zero SHALL hold stable until out_ready is sampled high.
REQ-025 On the edge where out_valid & out_ready, the state SHALL return to IDLE; the earliest next accept is the following edge, so throughput is one operation per latency+1 cycles.
REQ-026 in_valid asserted outside IDLE SHALL have no effect.
REQ-027 out_zero SHALL be combinationally derived from out_data.

Reset
REQ-028 While rst_n = 0, independent of clk:
- state SHALL be IDLE;
- working register, remaining count and captured mode SHALL be 0.
Resulting outputs: in_ready = 1, out_valid = 0, out_data = 0, out_zero = 1.
REQ-029 Reset asserted during SHIFT or DONE SHALL abort the operation with no output handshake; the first accept after release SHALL start a fresh operation.

Structure
REQ-030 A shared package SHALL hold:
- the mode encoding constants (SLL/SRL/SRA/ROL);
- the FSM state enumeration.
REQ-031 One sub-module, shift_step, SHALL implement the combinational shift of a WIDTH-bit value by 0..STEP positions for a given mode; shift_unit instantiates it once.
REQ-032 No multiplier, divider or full WIDTH-wide barrel shifter SHALL be inferred in shift_unit.

Verification (WIDTH=16, STEP=2)
REQ-033 SLL 0x0001 amt 2, out_ready=1 -> out_data 0x0004, out_valid 2 cycles after accept, out_zero 0.
REQ-034 SRA 0x8000 amt 15 -> 0xFFFF after 9 cycles; SRL 0xF000 amt 4 -> 0x0F00 after 3 cycles.
REQ-035 ROL 0x8001 amt 3 -> 0x000C after 3 cycles; SLL 0x00FF amt 0 -> 0x00FF after 1 cycle.
REQ-036 SRL 0x0001 amt 1 with out_ready=0 for 5 cycles -> out_data 0x0000, out_zero 1, both held stable; return to IDLE on the out_ready edge; in_valid pulses during SHIFT/DONE ignored.
REQ-037 rst_n low mid-SHIFT of SLL 0x1234 amt 12 -> immediate in_ready 1, out_valid 0, out_data 0; no result emitted.
REQ-038 Randomised sweep: all modes and amounts 0..15 against a golden model -> exact data match and latency per REQ-021.
